// File: rtl/arithmetic_decoder.sv
// Multi-symbol arithmetic decoder: pulls stream bytes, decodes one symbol per
// request against an inverse-CDF table read one entry per cycle, and keeps the
// rng/dif/cnt window state across requests.
module arithmetic_decoder #(
    parameter int unsigned GENERAL_DATA_16      = 16,
    parameter int unsigned GENERAL_DATA_32      = 32,
    parameter int unsigned GENERAL_SYMBOL_WIDTH = 4
) (
    input  logic                            general_clk,
    input  logic                            reset,
    input  logic [7:0]                      byte_data,
    input  logic                            byte_valid,
    output logic                            byte_ready,
    input  logic                            dec_valid,
    input  logic [GENERAL_SYMBOL_WIDTH:0]   dec_nsyms,
    output logic                            dec_ready,
    output logic [GENERAL_SYMBOL_WIDTH-1:0] cdf_idx,
    input  logic [GENERAL_DATA_16-1:0]      cdf_icdf,
    output logic                            sym_valid,
    input  logic                            sym_ready,
    output logic [GENERAL_SYMBOL_WIDTH-1:0] sym_out,
    output logic [GENERAL_DATA_16-1:0]      rng_out
);

    localparam int unsigned D16   = GENERAL_DATA_16;
    localparam int unsigned D32   = GENERAL_DATA_32;
    localparam int unsigned W     = GENERAL_SYMBOL_WIDTH;
    localparam int unsigned NS_W  = W + 1;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned RHI_W = D16 - 8;
    localparam int unsigned IHI_W = D16 - 6;
    localparam int unsigned V_W   = RHI_W + IHI_W;
    localparam int unsigned D_W   = $clog2(D16);

    typedef enum logic [2:0] {
        ST_FILL,
        ST_IDLE,
        ST_SEARCH,
        ST_NORM,
        ST_REFILL,
        ST_OUT
    } state_t;

    state_t                  state_q, state_d;
    logic [D16-1:0]          rng_q, rng_d;
    logic [D16-1:0]          u_q, u_d;
    logic [D32-1:0]          dif_q, dif_d;
    logic signed [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]            ret_q, ret_d;
    logic [W-1:0]            n_q, n_d;
    logic [W-1:0]            sym_q, sym_d;
    logic                    byte_ready_q, byte_ready_d;
    logic                    dec_ready_q, dec_ready_d;
    logic                    sym_valid_q, sym_valid_d;

    logic [CNT_W-1:0]        fill_shift_w;
    logic signed [CNT_W-1:0] cnt_fill_w;
    logic signed [CNT_W-1:0] cnt_norm_w;
    logic [V_W-1:0]          prod_w;
    logic [V_W-1:0]          v_w;
    logic [W-1:0]            n_minus_ret_w;
    logic [D16-1:0]          c_w;
    logic                    hit_w;
    logic [D_W-1:0]          norm_sh_w;
    logic                    unused_icdf_lsb;

    // Low icdf bits never reach the product.
    assign unused_icdf_lsb = ^cdf_icdf[5:0];

    // Byte insertion point and counter update for FILL/REFILL.
    always_comb begin
        fill_shift_w = 6'd8 - $unsigned(cnt_q);
        cnt_fill_w   = cnt_q + 6'sd8;
    end

    // Split point for the current icdf entry; the last symbol always splits at zero.
    always_comb begin
        prod_w        = V_W'(rng_q[D16-1:8]) * V_W'(cdf_icdf[D16-1:6]);
        n_minus_ret_w = n_q - ret_q;
        c_w           = dif_q[D32-1:D32-D16];
        v_w           = '0;
        if (ret_q != n_q) begin
            v_w = (prod_w >> 1) + (V_W'(n_minus_ret_w) << 2);
        end
        hit_w = V_W'(c_w) >= v_w;
    end

    // Renormalisation shift: distance of rng's leading one from the MSB.
    always_comb begin
        norm_sh_w = D_W'(D16 - 1);
        for (int i = 0; i < int'(D16); i++) begin
            if (rng_q[i]) begin
                norm_sh_w = D_W'(int'(D16) - 1 - i);
            end
        end
        cnt_norm_w = cnt_q - $signed(CNT_W'(norm_sh_w));
    end

    // Next-state and datapath updates; handshake outputs follow the next state.
    always_comb begin
        state_d      = state_q;
        rng_d        = rng_q;
        u_d          = u_q;
        dif_d        = dif_q;
        cnt_d        = cnt_q;
        ret_d        = ret_q;
        n_d          = n_q;
        sym_d        = sym_q;
        byte_ready_d = 1'b0;
        dec_ready_d  = 1'b0;
        sym_valid_d  = 1'b0;

        case (state_q)
            ST_FILL, ST_REFILL: begin
                if (byte_valid && byte_ready_q) begin
                    dif_d = dif_q ^ (D32'(byte_data) << fill_shift_w);
                    cnt_d = cnt_fill_w;
                    if (cnt_fill_w > 6'sd8) begin
                        state_d = (state_q == ST_FILL) ? ST_IDLE : ST_OUT;
                    end
                end
            end
            ST_IDLE: begin
                if (dec_valid && dec_ready_q) begin
                    n_d     = W'(dec_nsyms - NS_W'(1));
                    u_d     = rng_q;
                    ret_d   = '0;
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (hit_w) begin
                    sym_d   = ret_q;
                    rng_d   = u_q - D16'(v_w);
                    dif_d   = dif_q - (D32'(v_w) << 16);
                    state_d = ST_NORM;
                end else begin
                    u_d   = D16'(v_w);
                    ret_d = ret_q + W'(1);
                end
            end
            ST_NORM: begin
                rng_d   = rng_q << norm_sh_w;
                dif_d   = ((dif_q + D32'(1)) << norm_sh_w) - D32'(1);
                cnt_d   = cnt_norm_w;
                state_d = cnt_norm_w[CNT_W-1] ? ST_REFILL : ST_OUT;
            end
            ST_OUT: begin
                if (sym_ready && sym_valid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_FILL;
        endcase

        byte_ready_d = (state_d == ST_FILL) || (state_d == ST_REFILL);
        dec_ready_d  = (state_d == ST_IDLE);
        sym_valid_d  = (state_d == ST_OUT);
    end

    // State and window registers; reset abandons any decode in flight.
    always_ff @(posedge general_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_FILL;
            rng_q        <= D16'(16'h8000);
            u_q          <= '0;
            dif_q        <= D32'(32'h7FFF_FFFF);
            cnt_q        <= -6'sd15;
            ret_q        <= '0;
            n_q          <= '0;
            sym_q        <= '0;
            byte_ready_q <= 1'b1;
            dec_ready_q  <= 1'b0;
            sym_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rng_q        <= rng_d;
            u_q          <= u_d;
            dif_q        <= dif_d;
            cnt_q        <= cnt_d;
            ret_q        <= ret_d;
            n_q          <= n_d;
            sym_q        <= sym_d;
            byte_ready_q <= byte_ready_d;
            dec_ready_q  <= dec_ready_d;
            sym_valid_q  <= sym_valid_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign dec_ready  = dec_ready_q;
    assign sym_valid  = sym_valid_q;
    assign sym_out    = sym_q;
    assign cdf_idx    = ret_q;
    assign rng_out    = rng_q;

endmodule

// File: tb/tb_arithmetic_decoder.sv
// Bench for arithmetic_decoder: directed scenarios plus a long random replay
// checked against an integer-level reference decoder.
module tb_arithmetic_decoder;

    localparam int W = 4;
    localparam longint MASK32 = 64'hFFFF_FFFF;

    logic         general_clk = 1'b0;
    logic         reset;
    logic [7:0]   byte_data;
    logic         byte_valid;
    logic         byte_ready;
    logic         dec_valid;
    logic [W:0]   dec_nsyms;
    logic         dec_ready;
    logic [W-1:0] cdf_idx;
    logic [15:0]  cdf_icdf;
    logic         sym_valid;
    logic         sym_ready;
    logic [W-1:0] sym_out;
    logic [15:0]  rng_out;

    logic [15:0]  icdf_tab [16];

    int     checks = 0;
    int     errors = 0;
    int     stream[$];
    int     bptr;
    int     mptr;
    int     m_rng;
    int     m_cnt;
    longint m_dif;

    arithmetic_decoder dut (
        .general_clk (general_clk),
        .reset       (reset),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .dec_valid   (dec_valid),
        .dec_nsyms   (dec_nsyms),
        .dec_ready   (dec_ready),
        .cdf_idx     (cdf_idx),
        .cdf_icdf    (cdf_icdf),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .sym_out     (sym_out),
        .rng_out     (rng_out)
    );

    assign cdf_icdf = icdf_tab[cdf_idx];

    always #5 general_clk = ~general_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream bytes are generated lazily so model and DUT always see the same data.
    function automatic int stream_at(input int i);
        while (stream.size() <= i) stream.push_back(int'($urandom_range(255)));
        return stream[i];
    endfunction

    // ---------------- reference model ----------------
    function automatic int model_pull();
        int nb = 0;
        do begin
            m_dif = (m_dif ^ (longint'(stream_at(mptr)) << (8 - m_cnt))) & MASK32;
            mptr++;
            m_cnt += 8;
            nb++;
        end while (m_cnt <= 8);
        return nb;
    endfunction

    function automatic void model_reset();
        int nb;
        m_rng = 32768;
        m_dif = 64'h7FFF_FFFF;
        m_cnt = -15;
        mptr  = 0;
        nb    = model_pull();
    endfunction

    function automatic int split_at(input int rng, input int r, input int last);
        if (r == last) return 0;
        return (((rng / 256) * (int'(icdf_tab[r]) / 64)) / 2) + 4 * (last - r);
    endfunction

    function automatic void model_decode(input int n, output int sym, output int nb);
        int last = n - 1;
        int c    = int'((m_dif >> 16) & 64'hFFFF);
        int u    = m_rng;
        int r    = 0;
        int v    = split_at(m_rng, 0, last);
        int d    = 0;
        while (c < v) begin
            u = v;
            r++;
            v = split_at(m_rng, r, last);
        end
        m_rng = (u - v) & 16'hFFFF;
        m_dif = (m_dif - (longint'(v) << 16)) & MASK32;
        while (d < 15 && (m_rng * (1 << d)) < 32768) d++;
        m_rng = (m_rng << d) & 16'hFFFF;
        m_dif = (((m_dif + 1) << d) - 1) & MASK32;
        m_cnt -= d;
        nb = 0;
        if (m_cnt < 0) nb = model_pull();
        sym = r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic feed_tick();
        logic xb;
        check_eq("ready_exclusive", 64'(byte_ready && dec_ready), 64'd0);
        xb = byte_valid && byte_ready;
        @(posedge general_clk);
        #1;
        if (xb) bptr++;
        byte_data = 8'(stream_at(bptr));
    endtask

    task automatic rand_table(input int n);
        int prev = 32767;
        for (int i = 0; i < 16; i++) begin
            if (i < n - 1) begin
                prev = int'($urandom_range(prev, 0));
                icdf_tab[i] = 16'(prev);
            end else begin
                icdf_tab[i] = 16'($urandom);
            end
        end
    endtask

    task automatic start_reset(input bit use_prefix, input int pbyte);
        reset      = 1'b1;
        dec_valid  = 1'b0;
        sym_ready  = 1'b0;
        byte_valid = 1'b1;
        stream.delete();
        if (use_prefix) repeat (3) stream.push_back(pbyte);
        bptr      = 0;
        byte_data = 8'(stream_at(0));
    endtask

    task automatic end_reset();
        repeat (2) @(posedge general_clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_fill(output int cyc);
        cyc = 0;
        while (!dec_ready && cyc < 20) begin
            feed_tick();
            cyc++;
        end
        check_eq("fill_done", 64'(dec_ready), 64'd1);
        check_eq("fill_bytes", 64'(bptr), 64'(mptr));
    endtask

    task automatic send_req(input int n, output bit ok);
        dec_nsyms = (W+1)'(n);
        dec_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            ok = dec_ready;
            feed_tick();
            if (ok) break;
        end
        dec_valid = 1'b0;
        check_eq("req_accepted", 64'(ok), 64'd1);
    endtask

    task automatic do_decode(input int n, input int hold, input bit gap);
        int esym, nb, lat, e;
        bit ok;
        model_decode(n, esym, nb);
        lat = esym + 2 + nb + ((gap && nb > 0) ? 5 : 0);
        send_req(n, ok);
        if (!ok) return;
        e = 0;
        while (!sym_valid && e < 80) begin
            if (e <= esym) check_eq("cdf_idx", 64'(cdf_idx), 64'(e));
            check_eq("busy_dec_ready", 64'(dec_ready), 64'd0);
            if (gap && nb > 0 && e == esym + 2) begin
                byte_valid = 1'b0;
                repeat (5) begin
                    check_eq("refill_byte_ready", 64'(byte_ready), 64'd1);
                    check_eq("refill_sym_valid", 64'(sym_valid), 64'd0);
                    feed_tick();
                    e++;
                end
                byte_valid = 1'b1;
            end else begin
                feed_tick();
                e++;
            end
        end
        check_eq("latency", 64'(e), 64'(lat));
        check_eq("sym_out", 64'(sym_out), 64'(esym));
        check_eq("rng_out", 64'(rng_out), 64'(m_rng));
        repeat (hold) begin
            feed_tick();
            check_eq("hold_sym_valid", 64'(sym_valid), 64'd1);
            check_eq("hold_sym_out", 64'(sym_out), 64'(esym));
            check_eq("hold_dec_ready", 64'(dec_ready), 64'd0);
            check_eq("hold_byte_ready", 64'(byte_ready), 64'd0);
        end
        sym_ready = 1'b1;
        feed_tick();
        sym_ready = 1'b0;
        check_eq("post_sym_valid", 64'(sym_valid), 64'd0);
        check_eq("post_dec_ready", 64'(dec_ready), 64'd1);
        check_eq("bytes_used", 64'(bptr), 64'(mptr));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int  cyc;
        bit  ok;
        dec_nsyms = '0;
        for (int i = 0; i < 16; i++) icdf_tab[i] = '0;

        // T1: reset values, then three zero bytes fill the window.
        start_reset(1'b1, 8'h00);
        #2;
        check_eq("rst_byte_ready", 64'(byte_ready), 64'd1);
        check_eq("rst_dec_ready", 64'(dec_ready), 64'd0);
        check_eq("rst_sym_valid", 64'(sym_valid), 64'd0);
        check_eq("rst_sym_out", 64'(sym_out), 64'd0);
        check_eq("rst_cdf_idx", 64'(cdf_idx), 64'd0);
        check_eq("rst_rng_out", 64'(rng_out), 64'h8000);
        end_reset();
        wait_fill(cyc);
        check_eq("t1_fill_cycles", 64'(cyc), 64'd3);
        check_eq("t1_bytes", 64'(bptr), 64'd3);
        check_eq("t1_dif", 64'(dut.dif_q), 64'h7FFF_FFFF);
        check_eq("t1_cnt", 64'($unsigned(dut.cnt_q)), 64'd9);

        // T2: binary symbol resolves at the first entry.
        rand_table(2);
        icdf_tab[0] = 16'd16384;
        do_decode(2, 0, 1'b0);
        check_eq("t2_sym", 64'(sym_out), 64'd0);
        check_eq("t2_rng", 64'(rng_out), 64'd65520);
        check_eq("t2_cnt", 64'($unsigned(dut.cnt_q)), 64'd7);
        check_eq("t2_dif_hi", 64'(dut.dif_q[31:16]), 64'hFFEF);

        // T4: tiny range forces a refill; stall the byte source for 5 cycles.
        rand_table(2);
        icdf_tab[0] = 16'h8000;
        do_decode(2, 0, 1'b1);
        check_eq("t4_rng", 64'(rng_out), 64'(m_rng));

        // T5: consumer back-pressure in OUT.
        rand_table(9);
        do_decode(9, 4, 1'b0);

        // T3: all-ones bytes push the search to the last symbol.
        start_reset(1'b1, 8'hFF);
        end_reset();
        wait_fill(cyc);
        rand_table(2);
        icdf_tab[0] = 16'd16384;
        do_decode(2, 0, 1'b0);
        check_eq("t3_sym", 64'(sym_out), 64'd1);
        check_eq("t3_rng", 64'(rng_out), 64'd32776);
        check_eq("t3_cnt", 64'($unsigned(dut.cnt_q)), 64'd8);

        // T6: reset lands in the middle of a long search.
        rand_table(16);
        send_req(16, ok);
        feed_tick();
        feed_tick();
        check_eq("t6_cdf_idx_mid", 64'(cdf_idx), 64'd2);
        #2;
        start_reset(1'b0, 0);
        #1;
        check_eq("t6_byte_ready", 64'(byte_ready), 64'd1);
        check_eq("t6_dec_ready", 64'(dec_ready), 64'd0);
        check_eq("t6_sym_valid", 64'(sym_valid), 64'd0);
        check_eq("t6_sym_out", 64'(sym_out), 64'd0);
        check_eq("t6_cdf_idx", 64'(cdf_idx), 64'd0);
        check_eq("t6_rng_out", 64'(rng_out), 64'h8000);
        end_reset();
        wait_fill(cyc);

        // Random replay against the reference decoder.
        for (int k = 0; k < 1000; k++) begin
            int n    = int'($urandom_range(16, 2));
            int hold = ($urandom_range(7) == 0) ? int'($urandom_range(3, 1)) : 0;
            bit gap  = ($urandom_range(3) == 0);
            rand_table(n);
            do_decode(n, hold, gap);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
